// File: rtl/uart_rx.sv
//-----------------------------------------------------------------------------
// uart_rx
//
// Receives 8N1 (by default) asynchronous serial frames for the vumeter host
// link. The line is sampled on the 16x oversample strobe from the clock
// generator. That strobe acts as a clock enable inside the single system
// clock domain. Each correctly framed byte is presented on `data` together
// with a one-cycle `valid` pulse. A low stop bit produces a one-cycle
// `frame_err` pulse instead, and `data` is left untouched.
//
// Parameters:
//   OVERSAMPLE  strobes per bit time (power of two, >= 8)
//   DATA_BITS   data bits per frame, LSB first, no parity, one stop bit
//
// Ports:
//   clk        in   system clock (100 MHz)
//   rst        in   synchronous active-low reset
//   os_tick    in   oversample strobe, one clk cycle wide
//   rxd        in   asynchronous serial input, idles high
//   data       out  last correctly framed byte
//   valid      out  one-cycle pulse: data was just updated
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   busy       out  receiver is not idle
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                 rxd_meta;
    logic                 rxd_s;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    logic                 valid_d;
    logic                 frame_err_d;
    logic                 shift_en;

    //-------------------------------------------------------------------------
    // Input synchronizer. Both flops reset to the idle (high) level, so the
    // release of reset can never look like a start edge.
    //-------------------------------------------------------------------------
    // NOTE: sequential state always uses non-blocking assignments, so every
    // flop samples the pre-edge values of the others (rxd_s takes the old
    // rxd_meta, which makes this a real two-stage chain).
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next-state logic. Without a strobe nothing moves.
    //-------------------------------------------------------------------------
    // NOTE: the combinational block assigns a default to every output first,
    // so no path through the case leaves state_d unassigned and no latch is
    // inferred.
    always_comb begin
        state_d = state_q;
        if (os_tick) begin
            unique case (state_q)
                IDLE:  if (!rxd_s) state_d = START;
                // At the centre of the start bit: still low means a genuine
                // start; high means a glitch, so drop it silently.
                START: if (tick_cnt == TICK_MID) state_d = rxd_s ? IDLE : DATA;
                DATA:  if (tick_cnt == TICK_LAST && bit_cnt == BIT_LAST) state_d = STOP;
                // The stop sample lands half a bit before the stop bit ends.
                // Returning to IDLE here lets a back-to-back start edge be
                // caught on time.
                STOP:  if (tick_cnt == TICK_LAST) state_d = rxd_s ? IDLE : BREAK;
                // A held-low line raises one error, not a stream of them.
                BREAK: if (rxd_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // FSM: output / strobe decode
    //-------------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != IDLE);
        shift_en    = os_tick && (state_q == DATA) && (tick_cnt == TICK_LAST);
        valid_d     = os_tick && (state_q == STOP) && (tick_cnt == TICK_LAST) &&  rxd_s;
        frame_err_d = os_tick && (state_q == STOP) && (tick_cnt == TICK_LAST) && !rxd_s;
    end

    //-------------------------------------------------------------------------
    // Datapath: counters, shift register, output registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= valid_d;
            frame_err <= frame_err_d;
            if (valid_d) begin
                data <= shreg;
            end

            if (os_tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (!rxd_s) tick_cnt <= '0;
                    end
                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end
                    // tick_cnt wraps from OVERSAMPLE-1 to 0 on its own, so
                    // every sample lands exactly one bit after the previous
                    // sample.
                    DATA: begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                        if (shift_en) begin
                            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                    STOP: begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
//-----------------------------------------------------------------------------
// tb_uart_rx
//
// Drives uart_rx with a 100 MHz clock, a free-running oversample strobe
// (54 cycles nominal) and a serial transmitter at 868 cycles per bit
// (115200 baud). The stimulus pushes the expected pulses onto a scoreboard
// queue. A monitor captures every valid/frame_err pulse, and each test pops
// the scoreboard and compares it against what was captured.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BIT_CYC  = 868;
    localparam int NOM_TICK = 54;
    // Stop-bit sample: 9.5 bit times after the start edge, +/- one tick.
    localparam int LAT_MIN  = (19 * BIT_CYC) / 2 - NOM_TICK;
    localparam int LAT_MAX  = (19 * BIT_CYC) / 2 + NOM_TICK;
    localparam int WAIT_MAX = 4 * BIT_CYC;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       os_tick = 1'b0;
    logic       rxd     = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int tick_period = NOM_TICK;
    int tick_div    = 0;
    int cyc         = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        int         cyc;
    } got_t;

    exp_t exp_q[$];
    got_t got_q[$];
    int   rd_idx     = 0;
    bit   both_seen  = 1'b0;
    int   edge_cyc   = 0;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .os_tick   (os_tick),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Oversample strobe generator and cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick_div >= tick_period - 1) begin
            tick_div <= 0;
            os_tick  <= 1'b1;
        end else begin
            tick_div <= tick_div + 1;
            os_tick  <= 1'b0;
        end
    end

    // Pulse monitor: records every cycle in which an output pulse is high.
    always @(negedge clk) begin
        if (valid && frame_err) both_seen <= 1'b1;
        if (valid)
            got_q.push_back('{is_err: 1'b0, d: data, cyc: cyc});
        else if (frame_err)
            got_q.push_back('{is_err: 1'b1, d: data, cyc: cyc});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    //-------------------------------------------------------------------------
    // Helpers
    //-------------------------------------------------------------------------
    function automatic exp_t mk_exp(input bit is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.d      = d;
        return e;
    endfunction

    // Send the first nbits of {stop, byte, start}, LSB (start bit) first.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int nbits);
        logic [9:0] fr;
        fr = {stop_val, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            rxd = fr[i];
            if (i == 0) edge_cyc = cyc;
            repeat (BIT_CYC - 1) @(negedge clk);
        end
    endtask

    // Pop every expected pulse and compare it with the next captured pulse,
    // then make sure nothing extra was captured.
    task automatic drain(input string name, input bit check_lat);
        exp_t e;
        got_t g;
        int   waited;
        int   lat;
        while (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            waited = 0;
            while (got_q.size() <= rd_idx && waited < WAIT_MAX) begin
                @(negedge clk);
                waited++;
            end
            vectors++;
            if (got_q.size() <= rd_idx) begin
                $display("FAIL %s: no pulse within %0d cycles, expected %s data=0x%02h",
                         name, WAIT_MAX, e.is_err ? "frame_err" : "valid", e.d);
                miscompares++;
            end else begin
                g = got_q[rd_idx];
                rd_idx++;
                if (g.is_err !== e.is_err || g.d !== e.d) begin
                    $display("FAIL %s: got %s data=0x%02h, expected %s data=0x%02h",
                             name, g.is_err ? "frame_err" : "valid", g.d,
                             e.is_err ? "frame_err" : "valid", e.d);
                    miscompares++;
                end
                if (check_lat) begin
                    lat = g.cyc - edge_cyc;
                    vectors++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        $display("FAIL %s_latency: pulse %0d cycles after start edge, expected %0d..%0d",
                                 name, lat, LAT_MIN, LAT_MAX);
                        miscompares++;
                    end
                end
            end
        end
        vectors++;
        if (got_q.size() != rd_idx) begin
            $display("FAIL %s_extra: %0d unexpected pulse cycles, expected 0",
                     name, got_q.size() - rd_idx);
            miscompares++;
            rd_idx = got_q.size();
        end
    endtask

    task automatic check_busy(input string name, input logic exp_busy);
        vectors++;
        if (busy !== exp_busy) begin
            $display("FAIL %s: busy=%b, expected %b", name, busy, exp_busy);
            miscompares++;
        end
    endtask

    //-------------------------------------------------------------------------
    // Tests
    //-------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (data !== 8'h00) begin
            $display("FAIL reset_data: data=0x%02h, expected 0x00", data);
            miscompares++;
        end
        vectors++;
        if (valid !== 1'b0) begin
            $display("FAIL reset_valid: valid=%b, expected 0", valid);
            miscompares++;
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            $display("FAIL reset_frame_err: frame_err=%b, expected 0", frame_err);
            miscompares++;
        end
        check_busy("reset_busy", 1'b0);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        drain("idle_line", 1'b0);
        check_busy("idle_busy", 1'b0);
    endtask

    task automatic test_single_byte();
        exp_q.push_back(mk_exp(1'b0, 8'hA5));
        send_frame(8'hA5, 1'b1, 10);
        drain("byte_a5", 1'b1);
        check_busy("byte_a5_busy", 1'b0);
    endtask

    task automatic test_false_start();
        @(negedge clk);
        rxd = 1'b0;
        repeat (2 * NOM_TICK) @(negedge clk);
        check_busy("glitch_busy_start", 1'b1);
        repeat (NOM_TICK) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        check_busy("glitch_busy_end", 1'b0);
        drain("glitch", 1'b0);
    endtask

    task automatic test_frame_error();
        exp_q.push_back(mk_exp(1'b1, 8'hA5));
        send_frame(8'h3C, 1'b0, 10);
        repeat (2 * BIT_CYC) @(negedge clk);
        check_busy("break_busy", 1'b1);
        drain("frame_err", 1'b0);
        vectors++;
        if (data !== 8'hA5) begin
            $display("FAIL frame_err_data: data=0x%02h, expected 0xA5", data);
            miscompares++;
        end
        rxd = 1'b1;
        repeat (BIT_CYC / 2) @(negedge clk);
        check_busy("break_release_busy", 1'b0);
        exp_q.push_back(mk_exp(1'b0, 8'h5A));
        send_frame(8'h5A, 1'b1, 10);
        drain("after_break_5a", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq = '{8'h00, 8'hFF, 8'h81};
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_exp(1'b0, seq[i]));
        for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1, 10);
        drain("back_to_back", 1'b0);
    endtask

    task automatic test_reset_abort();
        // Start bit plus data bits 0..3, then half of data bit 4.
        send_frame(8'h77, 1'b1, 5);
        @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CYC / 2) @(negedge clk);
        check_busy("abort_busy_before", 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_busy("abort_busy_in_reset", 1'b0);
        rst = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        drain("abort_77", 1'b0);
        exp_q.push_back(mk_exp(1'b0, 8'h12));
        send_frame(8'h12, 1'b1, 10);
        drain("after_abort_12", 1'b0);
    endtask

    task automatic test_baud_tolerance();
        int periods [2];
        periods = '{52, 56};
        for (int i = 0; i < 2; i++) begin
            tick_period = periods[i];
            repeat (BIT_CYC) @(negedge clk);
            exp_q.push_back(mk_exp(1'b0, 8'hC3));
            send_frame(8'hC3, 1'b1, 10);
            drain($sformatf("baud_tick%0d", periods[i]), 1'b0);
        end
        tick_period = NOM_TICK;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_abort();
        test_baud_tolerance();
        vectors++;
        if (both_seen) begin
            $display("FAIL pulse_exclusive: valid and frame_err high together=1, expected 0");
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
